// File: rtl/scc_serial_capture.sv
// scc_serial_capture: receive-side capture of the SCC transmit line.
// Samples an async 8N1 stream in the clk_14m domain, buffers complete bytes
// in a circular FIFO and hands them to the host with a valid/ready pop.
// Build option: define SCC_CAPTURE_PARITY_EN to add a parity bit (8P1 frame,
// sense chosen by PARITY_ODD) with a sticky parity_err flag.
module scc_serial_capture #(
    parameter int CLKS_PER_BIT    = 1491,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter bit PARITY_ODD      = 1'b0
) (
    input  logic                     clk_14m,
    input  logic                     reset,
    input  logic                     rxd,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow,
    output logic [7:0]               frame_err_cnt,
    output logic                     parity_err,
    input  logic                     clr_err
);

    localparam int                 PTR_W     = FIFO_DEPTH_LOG2 + 1;
    localparam int                 DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam logic [PTR_W-1:0]   DEPTH_CNT = PTR_W'(DEPTH);
    localparam logic [15:0]        HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]        BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             sync1_q, sync2_q, rs;
    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req, frame_err_evt, par_err_evt;
`ifdef SCC_CAPTURE_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       ferr_q, ferr_d;
    logic             full, pop, push_ok, ovf_evt;

    assign rs = sync2_q;

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // Receiver FSM: bit timing, deserialisation and stop/parity checks.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == 16'd0) ? cnt_q : cnt_q - 16'd1;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push_req      = 1'b0;
        frame_err_evt = 1'b0;
        par_err_evt   = 1'b0;
`ifdef SCC_CAPTURE_PARITY_EN
        par_bad_d     = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rs) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
`ifdef SCC_CAPTURE_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rs) begin
                        state_d   = S_DATA;
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;  // start bit vanished: glitch
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d   = {rs, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SCC_CAPTURE_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SCC_CAPTURE_PARITY_EN
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    if (rs != (^shift_q ^ PARITY_ODD)) begin
                        par_bad_d   = 1'b1;
                        par_err_evt = 1'b1;
                    end
                    cnt_d   = BIT_LOAD;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rs) begin
`ifdef SCC_CAPTURE_PARITY_EN
                        push_req = !par_bad_q;
`else
                        push_req = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_evt = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer, head-register and error-flag next-state logic.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == DEPTH_CNT);
        pop      = rx_valid_q & rx_ready;
        push_ok  = push_req & (!full | pop);
        ovf_evt  = push_req & full & !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rx_valid_d = (wr_ptr_d != rd_ptr_d);
        // The new head is the byte being written this cycle when the FIFO drains to it.
        if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            rx_data_d = shift_q;
        end else if (rx_valid_d) begin
            rx_data_d = mem_q[rd_ptr_d[FIFO_DEPTH_LOG2-1:0]];
        end else begin
            rx_data_d = rx_data_q;
        end
        // A coincident error beats the clear.
        overflow_d = ovf_evt | (overflow_q & !clr_err);
        if (frame_err_evt) begin
            ferr_d = clr_err ? 8'd1 : ((ferr_q == 8'hFF) ? ferr_q : ferr_q + 8'd1);
        end else begin
            ferr_d = clr_err ? 8'd0 : ferr_q;
        end
`ifdef SCC_CAPTURE_PARITY_EN
        parity_err_d = par_err_evt | (parity_err_q & !clr_err);
`endif
    end

    // State registers for the receiver, FIFO control and flags.
    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            ferr_q     <= 8'd0;
`ifdef SCC_CAPTURE_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overflow_q <= overflow_d;
            ferr_q     <= ferr_d;
`ifdef SCC_CAPTURE_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // FIFO storage write port.
    // NOTE: storage is not reset; pointers define which entries are meaningful.
    always_ff @(posedge clk_14m) begin
        if (push_ok) mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= shift_q;
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign fifo_count    = count;
    assign overflow      = overflow_q;
    assign frame_err_cnt = ferr_q;
`ifdef SCC_CAPTURE_PARITY_EN
    assign parity_err    = parity_err_q;
`else
    // No parity field on the line: the flag is held low whatever the sense setting.
    assign parity_err    = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_scc_serial_capture.sv
// tb_scc_serial_capture: self-checking bench for scc_serial_capture.
// Frames are serialised by the bench; a queue-based model tracks the expected
// FIFO contents and flags. Honours SCC_CAPTURE_PARITY_EN when defined.
module tb_scc_serial_capture;

    localparam int CPB   = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam bit PODD  = 1'b0;

    logic          clk_14m = 1'b0;
    logic          reset   = 1'b1;
    logic          rxd     = 1'b1;
    logic          rx_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic [7:0]    frame_err_cnt;
    logic          parity_err;

    int            vectors = 0;
    int            miscompares = 0;

    // Reference model state
    logic [7:0]    exp_q[$];
    int            exp_ferr = 0;
    logic          exp_ovf  = 1'b0;
    logic          exp_perr = 1'b0;

    scc_serial_capture #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH_LOG2(AW),
        .PARITY_ODD     (PODD)
    ) dut (
        .clk_14m      (clk_14m),
        .reset        (reset),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .frame_err_cnt(frame_err_cnt),
        .parity_err   (parity_err),
        .clr_err      (clr_err)
    );

    always #5 clk_14m = ~clk_14m;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One bit period on the line, starting and ending on a falling clock edge.
    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk_14m);
    endtask

    // Serialise one frame; optionally pulse rx_ready on the edge that samples
    // the stop bit. rise_edge reports the edge (counted from the start of the
    // stop bit) after which rx_valid first went high, or -1.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_flip, input bit pop_at_stop,
                              input int hold_low, output int rise_edge);
        logic was_valid;
        logic par_bad;
        rise_edge = -1;
        par_bad   = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef SCC_CAPTURE_PARITY_EN
        drive_bit((^data) ^ PODD ^ par_flip);
        par_bad = par_flip;
`endif
        rxd = stop_bit;
        was_valid = rx_valid;
        for (int i = 1; i <= CPB; i++) begin
            rx_ready = pop_at_stop && (i == 11);
            @(negedge clk_14m);
            if (!was_valid && rx_valid && rise_edge < 0) rise_edge = i;
        end
        rx_ready = 1'b0;
        if (!stop_bit) repeat (hold_low) @(negedge clk_14m);
        rxd = 1'b1;
        repeat (4) @(negedge clk_14m);
        // Model: a pop on the stop edge is taken before the push is judged.
        if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (par_bad) exp_perr = 1'b1;
        if (!stop_bit) begin
            exp_ferr = (exp_ferr == 255) ? 255 : exp_ferr + 1;
        end else if (!par_bad) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else exp_ovf = 1'b1;
        end
    endtask

    // Pop the head byte, comparing it against the model first.
    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        vectors++;
        if (rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s rx_valid: got %b want 1", tag, rx_valid);
        end
        vectors++;
        if (rx_data !== e) begin
            miscompares++;
            $display("FAIL %s rx_data: got %02h want %02h", tag, rx_data, e);
        end
        rx_ready = 1'b1;
        @(negedge clk_14m);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk_14m);
        clr_err = 1'b0;
        @(negedge clk_14m);
        exp_ovf  = 1'b0;
        exp_ferr = 0;
        exp_perr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_14m);
        vectors++;
        if ({rx_data, rx_valid, fifo_count, overflow, frame_err_cnt, parity_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_held outputs: got %02h/%b/%0d/%b/%0d/%b want all zero",
                     rx_data, rx_valid, fifo_count, overflow, frame_err_cnt, parity_err);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk_14m);
        vectors++;
        if ({rx_valid, fifo_count, overflow, frame_err_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_release outputs: got %b/%0d/%b/%0d want zero",
                     rx_valid, fifo_count, overflow, frame_err_cnt);
        end
    endtask

    task automatic test_basic();
        int rise;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, rise);
        // Stop midpoint is CPB/2 edges into the bit, plus 2 sync + 1 register.
        vectors++;
        if (rise !== CPB / 2 + 3) begin
            miscompares++;
            $display("FAIL basic latency: got %0d want %0d", rise, CPB / 2 + 3);
        end
        vectors++;
        if (fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL basic count: got %0d want 1", fifo_count);
        end
        pop_check("basic_pop");
        vectors++;
        if (rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL basic drained: got valid=%b count=%0d want 0/0", rx_valid, fifo_count);
        end
    endtask

    task automatic test_glitch();
        int rise;
        logic [7:0] d;
        rxd = 1'b0;
        repeat (4) @(negedge clk_14m);
        rxd = 1'b1;
        repeat (30) @(negedge clk_14m);
        vectors++;
        if (fifo_count !== 3'd0 || frame_err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL glitch: got count=%0d ferr=%0d want 0/0", fifo_count, frame_err_cnt);
        end
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0, 1'b0, 0, rise);
        pop_check("glitch_recover");
    endtask

    task automatic test_frame_err();
        int rise;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 40, rise);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, rise);
        vectors++;
        if (frame_err_cnt !== 8'(exp_ferr) || fifo_count !== 3'(exp_q.size())) begin
            miscompares++;
            $display("FAIL frame_err: got ferr=%0d count=%0d want %0d/%0d",
                     frame_err_cnt, fifo_count, exp_ferr, exp_q.size());
        end
        pop_check("frame_err_pop");
        pulse_clr();
        vectors++;
        if (frame_err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL frame_err_clr: got %0d want 0", frame_err_cnt);
        end
    endtask

    task automatic test_overflow();
        int rise;
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 0, rise);
        vectors++;
        if (fifo_count !== 3'(exp_q.size()) || overflow !== exp_ovf) begin
            miscompares++;
            $display("FAIL overflow state: got count=%0d ovf=%b want %0d/%b",
                     fifo_count, overflow, exp_q.size(), exp_ovf);
        end
        for (int i = 0; i < DEPTH; i++) pop_check("overflow_pop");
        pulse_clr();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clr: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        int rise;
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 0, rise);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, 0, rise);
        vectors++;
        if (overflow !== 1'b0 || fifo_count !== 3'(DEPTH)) begin
            miscompares++;
            $display("FAIL full_push_pop: got ovf=%b count=%0d want 0/%0d", overflow, fifo_count, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) pop_check("full_push_pop_drain");
    endtask

    task automatic test_one_entry_push_pop();
        int rise;
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 0, rise);
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b1, 0, rise);
        vectors++;
        if (fifo_count !== 3'd1 || rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL one_entry_push_pop: got count=%0d valid=%b want 1/1", fifo_count, rx_valid);
        end
        pop_check("one_entry_pop");
    endtask

    task automatic test_random();
        int rise;
        int npop;
        logic good;
        for (int n = 0; n < 20; n++) begin
            good = ($urandom_range(0, 5) != 0);
            send_frame(8'($urandom), good, 1'b0, 1'b0, $urandom_range(0, 20), rise);
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop && exp_q.size() > 0; k++) pop_check("random_pop");
            vectors++;
            if (fifo_count !== 3'(exp_q.size()) || frame_err_cnt !== 8'(exp_ferr) || overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL random[%0d]: got count=%0d ferr=%0d ovf=%b want %0d/%0d/%b",
                         n, fifo_count, frame_err_cnt, overflow, exp_q.size(), exp_ferr, exp_ovf);
            end
        end
        while (exp_q.size() > 0) pop_check("random_drain");
        pulse_clr();
    endtask

    task automatic test_parity();
        int rise;
`ifdef SCC_CAPTURE_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 0, rise);
        vectors++;
        if (parity_err !== 1'b1 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL parity_bad: got perr=%b count=%0d want 1/0", parity_err, fifo_count);
        end
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 0, rise);
        pop_check("parity_good");
        pulse_clr();
        vectors++;
        if (parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_clr: got %b want 0", parity_err);
        end
`else
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 0, rise);
        vectors++;
        if (parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_absent: got %b want 0", parity_err);
        end
        pop_check("no_parity_pop");
`endif
    endtask

    task automatic test_reset_mid_frame();
        int rise;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0, rise);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0, rise);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b1;
        #1;
        vectors++;
        if (rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: got valid=%b count=%0d want 0/0", rx_valid, fifo_count);
        end
        exp_q.delete();
        exp_ovf = 1'b0; exp_ferr = 0; exp_perr = 1'b0;
        rxd = 1'b1;
        @(negedge clk_14m);
        reset = 1'b0;
        repeat (4) @(negedge clk_14m);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 0, rise);
        pop_check("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_push_pop();
        test_one_entry_push_pop();
        test_random();
        test_parity();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
